// File: rtl/game_pkg.sv
// game_pkg: shared bomb state encoding, frozen game-state codes and playfield bounds.
package game_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, EXPLODE, COOLDOWN} bomb_state_t;
  localparam logic [4:0] FROZEN_0 = 5'b00000;
  localparam logic [4:0] FROZEN_1 = 5'b00001;
  localparam logic [4:0] FROZEN_2 = 5'b11111;
  localparam int FIELD_X_MIN = 32;
  localparam int FIELD_X_MAX = 608;
  localparam int FIELD_Y_MIN = 32;
  localparam int FIELD_Y_MAX = 448;
  function automatic logic is_frozen(input logic [4:0] a);
    return (a == FROZEN_0) || (a == FROZEN_1) || (a == FROZEN_2);
  endfunction
endpackage

// File: rtl/blast_rect.sv
// blast_rect: clips the 3x3-tile square around a tile to the playfield.
module blast_rect #(
  parameter int TILE  = 32,
  parameter int X_MIN = game_pkg::FIELD_X_MIN,
  parameter int X_MAX = game_pkg::FIELD_X_MAX,
  parameter int Y_MIN = game_pkg::FIELD_Y_MIN,
  parameter int Y_MAX = game_pkg::FIELD_Y_MAX
) (
  input  logic [9:0] tile_x,
  input  logic [9:0] tile_y,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] xs,
  output logic [9:0] ys
);
  localparam logic signed [11:0] T1 = 12'(TILE);
  localparam logic signed [11:0] T2 = 12'(2 * TILE);
  localparam logic signed [11:0] XL = 12'(X_MIN);
  localparam logic signed [11:0] XH = 12'(X_MAX);
  localparam logic signed [11:0] YL = 12'(Y_MIN);
  localparam logic signed [11:0] YH = 12'(Y_MAX);
  logic signed [11:0] tx, ty, lr, rr, tr, br, l, r, t, b, w, h;
  // signed arithmetic keeps tiles near the origin from wrapping before the clip
  always_comb begin
    tx = $signed({2'b00, tile_x});
    ty = $signed({2'b00, tile_y});
    lr = tx - T1;
    rr = tx + T2;
    tr = ty - T1;
    br = ty + T2;
    l = (lr < XL) ? XL : lr;
    r = (rr > XH) ? XH : rr;
    t = (tr < YL) ? YL : tr;
    b = (br > YH) ? YH : br;
    w = r - l;
    h = b - t;
  end
  assign x  = l[9:0];
  assign y  = t[9:0];
  assign xs = w[9:0];
  assign ys = h[9:0];
endmodule

// File: rtl/bomb_ctrl.sv
// bomb_ctrl: per-player bomb life cycle (place, fuse, explode, cooldown) with
// sprite position and clipped kill rectangle for the opposing player.
module bomb_ctrl #(
  parameter int FUSE_FRAMES  = 120,
  parameter int BLAST_FRAMES = 30,
  parameter int COOL_FRAMES  = 15,
  parameter int TILE         = 32,
  parameter int USER_W       = 18,
  parameter int USER_H       = 26,
  parameter int FIELD_X_MIN  = game_pkg::FIELD_X_MIN,
  parameter int FIELD_X_MAX  = game_pkg::FIELD_X_MAX,
  parameter int FIELD_Y_MIN  = game_pkg::FIELD_Y_MIN,
  parameter int FIELD_Y_MAX  = game_pkg::FIELD_Y_MAX
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [4:0] allow,
  input  logic       bomb_drop,
  input  logic [9:0] userX,
  input  logic [9:0] userY,
  output logic [9:0] spriteX,
  output logic [9:0] spriteY,
  output logic       bomb_active,
  output logic       blast_active,
  output logic [9:0] bombX,
  output logic [9:0] bombY,
  output logic [9:0] bombXS,
  output logic [9:0] bombYS
);
  import game_pkg::*;
  localparam logic [9:0] MASK = ~10'(TILE - 1);
  bomb_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [9:0] sprite_x_q, sprite_x_d, sprite_y_q, sprite_y_d;
  logic [9:0] rx, ry, rxs, rys;
  logic drop_q, frozen, drop_edge;
  assign frozen    = is_frozen(allow);
  assign drop_edge = bomb_drop & ~drop_q & ~frozen;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sprite_x_d = sprite_x_q;
    sprite_y_d = sprite_y_q;
    if (!frozen) begin
      case (state_q)
        IDLE: if (drop_edge) begin
          sprite_x_d = (userX + 10'(USER_W / 2)) & MASK;
          sprite_y_d = (userY + 10'(USER_H / 2)) & MASK;
          cnt_d      = 16'(FUSE_FRAMES - 1);
          state_d    = ARMED;
        end
        ARMED: begin
          state_d = (cnt_q == '0) ? EXPLODE : ARMED;
          cnt_d   = (cnt_q == '0) ? 16'(BLAST_FRAMES - 1) : cnt_q - 16'd1;
        end
        EXPLODE: begin
          state_d = (cnt_q == '0) ? COOLDOWN : EXPLODE;
          cnt_d   = (cnt_q == '0) ? 16'(COOL_FRAMES - 1) : cnt_q - 16'd1;
        end
        default: begin
          state_d = (cnt_q == '0) ? IDLE : COOLDOWN;
          cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 16'd1;
        end
      endcase
    end
  end
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      sprite_x_q <= '0;
      sprite_y_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drop_q     <= bomb_drop;
      sprite_x_q <= sprite_x_d;
      sprite_y_q <= sprite_y_d;
    end
  end
  blast_rect #(
    .TILE(TILE), .X_MIN(FIELD_X_MIN), .X_MAX(FIELD_X_MAX),
    .Y_MIN(FIELD_Y_MIN), .Y_MAX(FIELD_Y_MAX)
  ) u_rect (
    .tile_x(sprite_x_q), .tile_y(sprite_y_q),
    .x(rx), .y(ry), .xs(rxs), .ys(rys)
  );
  // every output derives from flops only, so reset clears them immediately
  assign spriteX      = sprite_x_q;
  assign spriteY      = sprite_y_q;
  assign bomb_active  = (state_q == ARMED);
  assign blast_active = (state_q == EXPLODE);
  assign bombX        = blast_active ? rx  : '0;
  assign bombY        = blast_active ? ry  : '0;
  assign bombXS       = blast_active ? rxs : '0;
  assign bombYS       = blast_active ? rys : '0;
endmodule

// File: tb/tb_bomb_ctrl.sv
// tb_bomb_ctrl: scoreboard bench; a frame-count reference model predicts every frame's outputs.
module tb_bomb_ctrl;
  localparam int FUSE = 120, BLAST = 30, COOL = 15;
  logic frame_clk = 1'b0, Reset_n = 1'b0, bomb_drop = 1'b0;
  logic [4:0] allow = 5'd4;
  logic [9:0] userX = '0, userY = '0;
  logic [9:0] spriteX, spriteY, bombX, bombY, bombXS, bombYS;
  logic bomb_active, blast_active;
  logic [61:0] got;
  logic [61:0] exp_q[$];
  int checks = 0, errors = 0, frame_no = 0;
  bit m_busy = 0, m_dropq = 0;
  int m_n = 0, m_sx = 0, m_sy = 0;

  bomb_ctrl dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .allow(allow), .bomb_drop(bomb_drop),
    .userX(userX), .userY(userY), .spriteX(spriteX), .spriteY(spriteY),
    .bomb_active(bomb_active), .blast_active(blast_active),
    .bombX(bombX), .bombY(bombY), .bombXS(bombXS), .bombYS(bombYS)
  );

  always #5 frame_clk = ~frame_clk;
  assign got = {spriteX, spriteY, bomb_active, blast_active, bombX, bombY, bombXS, bombYS};

  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction
  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction

  // the phase is derived purely from how many live frames have passed since the drop
  function automatic logic [61:0] model_obs();
    logic arm, bl;
    logic [9:0] x, y, xs, ys;
    int l, r, t, b;
    arm = m_busy && m_n < FUSE;
    bl  = m_busy && m_n >= FUSE && m_n < FUSE + BLAST;
    l = imax(m_sx - 32, 32);  r = imin(m_sx + 64, 608);
    t = imax(m_sy - 32, 32);  b = imin(m_sy + 64, 448);
    x  = bl ? 10'(l) : '0;     y  = bl ? 10'(t) : '0;
    xs = bl ? 10'(r - l) : '0; ys = bl ? 10'(b - t) : '0;
    return {10'(m_sx), 10'(m_sy), arm, bl, x, y, xs, ys};
  endfunction

  task automatic step(input logic drop, input int ux, input int uy, input logic [4:0] al);
    bit frz, edge_seen;
    @(negedge frame_clk);
    Reset_n = 1'b1; bomb_drop = drop; userX = 10'(ux); userY = 10'(uy); allow = al;
    frz = (al == 5'd0) || (al == 5'd1) || (al == 5'd31);
    edge_seen = drop && !m_dropq && !frz;
    m_dropq = drop;
    if (!frz) begin
      if (m_busy) begin
        m_n++;
        if (m_n >= FUSE + BLAST + COOL) m_busy = 0;
      end else if (edge_seen) begin
        m_busy = 1; m_n = 0;
        m_sx = ((ux + 9) % 1024) & ~31;
        m_sy = ((uy + 13) % 1024) & ~31;
      end
    end
    exp_q.push_back(model_obs());
  endtask

  task automatic run(input int n, input int ux, input int uy);
    for (int i = 0; i < n; i++) step(1'b0, ux, uy, 5'd4);
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    #1 Reset_n = 1'b0; bomb_drop = 1'b0;
    #1 checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL async_reset got %h exp 0", got);
    end
    m_busy = 0; m_dropq = 0; m_n = 0; m_sx = 0; m_sy = 0;
    exp_q.push_back('0);
  endtask

  initial begin
    logic [61:0] e;
    forever begin
      @(posedge frame_clk);
      #1 frame_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL frame %0d got %h exp %h", frame_no, got, e);
        end
      end
    end
  end

  initial begin
    logic [4:0] al;
    do_reset();
    run(3, 300, 200);
    step(1'b1, 300, 200, 5'd4);
    for (int i = 0; i < 130; i++) step(i % 17 == 3, 300, 200, 5'd4);
    run(40, 300, 200);
    step(1'b1, 39, 35, 5'd4);
    run(170, 39, 35);
    for (int i = 0; i < 300; i++) step(1'b1, 100, 100, 5'd4);
    run(2, 100, 100);
    step(1'b1, 400, 300, 5'd4);
    run(40, 400, 300);
    for (int i = 0; i < 10; i++) step(i == 4, 400, 300, (i % 3 == 0) ? 5'd31 : 5'd1);
    run(140, 400, 300);
    step(1'b1, 5, 420, 5'd4);
    run(125, 5, 420);
    do_reset();
    step(1'b1, 600, 40, 5'd4);
    run(170, 600, 40);
    for (int i = 0; i < 2000; i++) begin
      al = ($urandom_range(0, 9) == 0) ? ((($urandom & 1) != 0) ? 5'd1 : 5'd0) : 5'($urandom_range(2, 30));
      step($urandom_range(0, 19) == 0, $urandom_range(0, 630), $urandom_range(0, 470), al);
    end
    repeat (3) @(posedge frame_clk);
    #2 checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
